// File: rtl/wb_ram_slave.sv
// Wishbone classic word RAM with byte lanes and programmable wait states; WB_RAM_ERR_EN enables out-of-range error response.
// Latency: stb sampled in cycle T -> ack/err in cycle T+1+WAIT_CYCLES. No stall beyond wait states; one IDLE cycle between terminations.
module wb_ram_slave #(
    parameter int SIZE        = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int TAGSIZE     = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    input  logic [3:0]         wb_sel_i,
    input  logic [TAGSIZE-1:0] wb_tgd_i,
    output logic [31:0]        wb_dat_o,
    output logic [TAGSIZE-1:0] wb_tgd_o,
    output logic               wb_ack_o,
    output logic               wb_err_o
);
    localparam int         AW        = $clog2(SIZE);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic               we_q, we_d;
    logic [31:0]        wdat_q, wdat_d;
    logic [3:0]         sel_q, sel_d;
    logic [TAGSIZE-1:0] tgd_q, tgd_d;
    logic               oor_q, oor_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rdat_q, rdat_d;
    logic [TAGSIZE-1:0] tgo_q, tgo_d;

    logic [31:0]        mem [SIZE];
    logic               mem_we;
    logic               enter_resp;
    logic               req_oor;

    logic [AW-1:0]      cur_idx;
    logic               cur_we;
    logic [31:0]        cur_dat;
    logic [3:0]         cur_sel;
    logic [TAGSIZE-1:0] cur_tgd;
    logic               cur_oor;

    logic               unused_adr;
    assign unused_adr = ^wb_adr_i;

`ifdef WB_RAM_ERR_EN
    assign req_oor = ({2'b00, wb_adr_i[31:2]} >= 32'(SIZE));
`else
    assign req_oor = 1'b0;
`endif

    // With zero wait states the response is formed straight from the bus inputs.
    always_comb begin
        if (state_q == IDLE) begin
            cur_idx = wb_adr_i[AW+1:2];
            cur_we  = wb_we_i;
            cur_dat = wb_dat_i;
            cur_sel = wb_sel_i;
            cur_tgd = wb_tgd_i;
            cur_oor = req_oor;
        end else begin
            cur_idx = idx_q;
            cur_we  = we_q;
            cur_dat = wdat_q;
            cur_sel = sel_q;
            cur_tgd = tgd_q;
            cur_oor = oor_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        we_d       = we_q;
        wdat_d     = wdat_q;
        sel_d      = sel_q;
        tgd_d      = tgd_q;
        oor_d      = oor_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdat_d     = rdat_q;
        tgo_d      = tgo_q;
        mem_we     = 1'b0;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    idx_d  = wb_adr_i[AW+1:2];
                    we_d   = wb_we_i;
                    wdat_d = wb_dat_i;
                    sel_d  = wb_sel_i;
                    tgd_d  = wb_tgd_i;
                    oor_d  = req_oor;
                    if (WAIT_CYCLES == 0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_resp) begin
            state_d = RESP;
            ack_d   = !cur_oor;
            err_d   = cur_oor;
            tgo_d   = cur_tgd;
            mem_we  = cur_we && !cur_oor && !rst_i;
            rdat_d  = (cur_we || cur_oor) ? 32'd0 : mem[cur_idx];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= 32'd0;
            sel_q   <= 4'd0;
            tgd_q   <= '0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= 32'd0;
            tgo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            tgd_q   <= tgd_d;
            oor_q   <= oor_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            tgo_q   <= tgo_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur_sel[b]) begin
                    mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
                end
            end
        end
    end

    assign wb_dat_o = rdat_q;
    assign wb_tgd_o = tgo_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule
